// File: rtl/nand_target_if.sv
// nand_target_if: NAND flash pin bundle between controller (master) and target (slave)
interface nand_target_if;
  logic F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP;
  logic [7:0] F_DIO_in, F_DIO_out;
  logic F_DIO_oe, F_nRB;
  modport master(output F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, F_DIO_in, input F_DIO_out, F_DIO_oe, F_nRB);
  modport slave(input F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, F_DIO_in, output F_DIO_out, F_DIO_oe, F_nRB);
endinterface

// File: rtl/nand_target.sv
// nand_target: pin-level NAND flash target with a small page array for controller loop-back
module nand_target #(
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES = 16,
  parameter int T_RD = 8,
  parameter int T_PROG = 16,
  parameter int T_ERS = 32,
  parameter int T_RST = 4
) (
  input  logic P_clk,
  input  logic P_nrst,
  nand_target_if.slave f,
  output logic [2:0] T_State,
  output logic T_Err
);
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int PW = $clog2(NUM_PAGES);
  localparam int PB = PAGE_BYTES * 8;
  typedef enum logic [2:0] {IDLE, ADDR, CONFIRM, BUSY, DOUT, DIN, STATUS} state_t;
  typedef enum logic [1:0] {OP_RD, OP_PG, OP_ER, OP_RST} op_t;
  logic [13:0] s1, s2;
  logic nce_s, cle_s, ale_s, nwe_s, nre_s, nwp_s, nwe_q, nre_q;
  logic [7:0] dio_s;
  state_t state;
  op_t op;
  logic [2:0] ai, an;
  logic [CW-1:0] col;
  logic [PW-1:0] page;
  logic fail, prot, nrb, err, dio_oe;
  logic [7:0] dio_out, bcnt;
  logic [PB-1:0] buf_q;
  logic [NUM_PAGES*PB-1:0] mem;
  logic strobe, is_cmd, is_addr, is_data, re_rise;
  assign {nce_s, cle_s, ale_s, nwe_s, nre_s, nwp_s, dio_s} = s2;
  assign strobe = ~nce_s & nwe_s & ~nwe_q;
  assign is_cmd = strobe & cle_s & ~ale_s;
  assign is_addr = strobe & ~cle_s & ale_s;
  assign is_data = strobe & ~cle_s & ~ale_s;
  assign re_rise = ~nce_s & nre_s & ~nre_q;
  assign f.F_DIO_out = dio_out;
  assign f.F_DIO_oe = dio_oe;
  assign f.F_nRB = nrb;
  assign T_State = state;
  assign T_Err = err;
  // two-flop synchronizer on every pin plus edge-detect history for nWE/nRE
  always_ff @(posedge P_clk or negedge P_nrst)
    if (!P_nrst) begin
      s1 <= {6'b111111, 8'h00};
      s2 <= {6'b111111, 8'h00};
      nwe_q <= 1'b1;
      nre_q <= 1'b1;
    end else begin
      s1 <= {f.F_nCE, f.F_CLE, f.F_ALE, f.F_nWE, f.F_nRE, f.F_nWP, f.F_DIO_in};
      s2 <= s1;
      nwe_q <= nwe_s;
      nre_q <= nre_s;
    end
  // command/address/data decode, busy timing, buffer and array updates
  always_ff @(posedge P_clk or negedge P_nrst)
    if (!P_nrst) begin
      state <= IDLE;
      op <= OP_RD;
      ai <= '0;
      an <= '0;
      col <= '0;
      page <= '0;
      fail <= 1'b0;
      prot <= 1'b0;
      nrb <= 1'b1;
      err <= 1'b0;
      dio_oe <= 1'b0;
      dio_out <= '0;
      bcnt <= '0;
      buf_q <= '0;
      mem <= '1;
    end else begin
      err <= strobe & cle_s & ale_s;
      dio_out <= state == DOUT ? buf_q[{col, 3'b000} +: 8] : state == STATUS ? {nwp_s, 1'b1, 5'b0, fail} : 8'h00;
      dio_oe <= ~nce_s & ~nre_s & (state == DOUT || state == STATUS);
      if (state == BUSY) begin
        if (bcnt == 0) begin
          nrb <= 1'b1;
          state <= op == OP_RD ? DOUT : IDLE;
          if (!prot && op == OP_PG) mem[{page, {CW+3{1'b0}}} +: PB] <= mem[{page, {CW+3{1'b0}}} +: PB] & buf_q;
          if (!prot && op == OP_ER) mem[{page, {CW+3{1'b0}}} +: PB] <= '1;
        end else bcnt <= bcnt - 8'd1;
      end
      if (is_cmd && dio_s == 8'hFF) begin
        state <= BUSY;
        op <= OP_RST;
        bcnt <= 8'(T_RST - 1);
        nrb <= 1'b0;
        fail <= 1'b0;
        prot <= 1'b0;
      end else if (is_cmd && state != BUSY) begin
        if (state == CONFIRM && dio_s == 8'h30 && op == OP_RD) begin
          buf_q <= mem[{page, {CW+3{1'b0}}} +: PB];
          state <= BUSY;
          bcnt <= 8'(T_RD - 1);
          nrb <= 1'b0;
        end else if ((state == CONFIRM && dio_s == 8'hD0 && op == OP_ER) || (state == DIN && dio_s == 8'h10)) begin
          state <= BUSY;
          bcnt <= op == OP_ER ? 8'(T_ERS - 1) : 8'(T_PROG - 1);
          nrb <= 1'b0;
          prot <= ~nwp_s;
          fail <= fail | ~nwp_s;
        end else if (state == ADDR || state == CONFIRM || state == DIN) begin
          err <= 1'b1;
          state <= IDLE;
        end else if (dio_s == 8'h00 || dio_s == 8'h80 || dio_s == 8'h60) begin
          state <= ADDR;
          ai <= '0;
          an <= dio_s == 8'h60 ? 3'd3 : 3'd5;
          op <= dio_s == 8'h00 ? OP_RD : dio_s == 8'h80 ? OP_PG : OP_ER;
        end else if (dio_s == 8'h70) state <= STATUS;
        else begin
          err <= 1'b1;
          state <= IDLE;
        end
      end else if (is_addr && state == ADDR) begin
        if (ai == 3'd0 && op != OP_ER) col <= dio_s[CW-1:0];
        if (ai == (op == OP_ER ? 3'd0 : 3'd2)) page <= dio_s[PW-1:0];
        ai <= ai + 3'd1;
        if (ai == an - 3'd1) state <= op == OP_PG ? DIN : CONFIRM;
      end else if (is_data && state == DIN) begin
        buf_q[{col, 3'b000} +: 8] <= dio_s;
        col <= col + 1'b1;
      end
      if (re_rise && state == DOUT) col <= col + 1'b1;
    end
endmodule

// File: tb/tb_nand_target.sv
// tb_nand_target: directed pin-level stimulus against nand_target with hand-computed expectations
module tb_nand_target;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [2:0] t_state;
  logic t_err;
  int n_chk = 0;
  int n_err = 0;
  int errs_seen = 0;
  int lo, e0;
  logic [7:0] d;
  logic oe;
  nand_target_if bus ();
  nand_target dut (.P_clk(clk), .P_nrst(nrst), .f(bus), .T_State(t_state), .T_Err(t_err));
  always #5 clk = ~clk;
  always @(negedge clk) if (t_err === 1'b1) errs_seen++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic cle, input logic ale, input logic [7:0] v);
    @(negedge clk);
    bus.F_CLE = cle;
    bus.F_ALE = ale;
    bus.F_DIO_in = v;
    bus.F_nWE = 1'b0;
    repeat (5) @(negedge clk);
    bus.F_nWE = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic cmd(input logic [7:0] c);
    cyc(1'b1, 1'b0, c);
  endtask
  task automatic dat(input logic [7:0] v);
    cyc(1'b0, 1'b0, v);
  endtask
  task automatic addr5(input logic [7:0] c, input logic [7:0] p);
    cyc(1'b0, 1'b1, c);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, p);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
  endtask
  task automatic busy_cmd(input logic [7:0] c, output int n);
    @(negedge clk);
    bus.F_CLE = 1'b1;
    bus.F_ALE = 1'b0;
    bus.F_DIO_in = c;
    bus.F_nWE = 1'b0;
    repeat (5) @(negedge clk);
    bus.F_nWE = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.F_nRB) n++;
      else if (n > 0) break;
    end
  endtask
  task automatic rd(output logic [7:0] v, output logic o);
    @(negedge clk);
    bus.F_nRE = 1'b0;
    repeat (5) @(negedge clk);
    v = bus.F_DIO_out;
    o = bus.F_DIO_oe;
    bus.F_nRE = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  initial begin
    bus.F_nCE = 1'b0;
    bus.F_CLE = 1'b0;
    bus.F_ALE = 1'b0;
    bus.F_nWE = 1'b1;
    bus.F_nRE = 1'b1;
    bus.F_nWP = 1'b1;
    bus.F_DIO_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_nrb", bus.F_nRB, 1);
    check("rst_dout", bus.F_DIO_out, 0);
    check("rst_oe", bus.F_DIO_oe, 0);
    check("rst_err", t_err, 0);
    check("rst_state", t_state, 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    cmd(8'h70);
    rd(d, oe);
    check("status_rst", d, 8'hC0);
    check("status_oe", oe, 1);
    check("status_nrb", bus.F_nRB, 1);
    check("status_state", t_state, 6);
    cmd(8'h80); addr5(8'h03, 8'h02); dat(8'hAA); dat(8'h55);
    busy_cmd(8'h10, lo);
    check("prog_busy", lo, 16);
    check("prog_state", t_state, 0);
    cmd(8'h00); addr5(8'h03, 8'h02);
    busy_cmd(8'h30, lo);
    check("read_busy", lo, 8);
    check("read_state", t_state, 4);
    rd(d, oe); check("read_b0", d, 8'hAA);
    rd(d, oe); check("read_b1", d, 8'h55);
    bus.F_nWP = 1'b0;
    cmd(8'h80); addr5(8'h00, 8'h05); dat(8'h00);
    busy_cmd(8'h10, lo);
    check("wp_busy", lo, 16);
    cmd(8'h70);
    rd(d, oe); check("wp_status", d, 8'h41);
    cmd(8'h00); addr5(8'h00, 8'h05);
    busy_cmd(8'h30, lo);
    rd(d, oe); check("wp_read", d, 8'hFF);
    bus.F_nWP = 1'b1;
    cmd(8'h60); cyc(1'b0, 1'b1, 8'h02); cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b1, 8'h00);
    busy_cmd(8'hD0, lo);
    check("erase_busy", lo, 32);
    cmd(8'h00); addr5(8'h03, 8'h02);
    busy_cmd(8'h30, lo);
    rd(d, oe); check("erase_b3", d, 8'hFF);
    rd(d, oe); check("erase_b4", d, 8'hFF);
    cmd(8'h80); addr5(8'h07, 8'h02); dat(8'hF0);
    busy_cmd(8'h10, lo);
    cmd(8'h80); addr5(8'h07, 8'h02); dat(8'h3C);
    busy_cmd(8'h10, lo);
    cmd(8'h00); addr5(8'h07, 8'h02);
    busy_cmd(8'h30, lo);
    rd(d, oe); check("and_b7", d, 8'h30);
    cmd(8'h80); addr5(8'h0F, 8'h03); dat(8'h11); dat(8'h22); dat(8'h33);
    busy_cmd(8'h10, lo);
    cmd(8'h00); addr5(8'h0F, 8'h03);
    busy_cmd(8'h30, lo);
    rd(d, oe); check("wrap_b15", d, 8'h11);
    rd(d, oe); check("wrap_b0", d, 8'h22);
    rd(d, oe); check("wrap_b1", d, 8'h33);
    cmd(8'h80); addr5(8'h0F, 8'h03); dat(8'h00);
    cmd(8'h10);
    busy_cmd(8'hFF, lo);
    check("abort_busy", lo, 6);
    check("abort_state", t_state, 0);
    cmd(8'h70);
    rd(d, oe); check("abort_status", d, 8'hC0);
    cmd(8'h00); addr5(8'h0F, 8'h03);
    busy_cmd(8'h30, lo);
    rd(d, oe); check("abort_keep", d, 8'h11);
    e0 = errs_seen;
    cmd(8'h00); addr5(8'h00, 8'h01);
    cmd(8'h10);
    repeat (3) @(negedge clk);
    check("badconf_err", errs_seen - e0, 1);
    check("badconf_state", t_state, 0);
    e0 = errs_seen;
    cyc(1'b1, 1'b1, 8'h00);
    check("cleale_err", errs_seen - e0, 1);
    check("cleale_state", t_state, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
